// File: rtl/rom_streamer.sv
// Streams ROM words [base..last] (wrapping) through a 2-deep valid/ready buffer; first word valid 2 clocks after start, holds under backpressure.
// Optional ROM_STREAMER_ABORT_EN adds abort_i, which flushes a run back to IDLE without a done_o pulse.
module rom_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] last_addr_i,
`ifdef ROM_STREAMER_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_dat_q [2];
  logic [DATA_WIDTH-1:0] buf_dat_d [2];
  logic                  buf_last_q [2];
  logic                  buf_last_d [2];
  logic                  done_q, done_d;
  logic                  abort_w;
  logic                  pop;
  logic [2:0]            occ;

`ifdef ROM_STREAMER_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign m_valid_o  = (cnt_q != 2'd0);
  assign m_data_o   = buf_dat_q[0];
  assign m_last_o   = buf_last_q[0] & m_valid_o;
  assign rom_addr_o = addr_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign pop        = m_valid_o & m_ready_i;
  // Words already owed to the buffer after this cycle's pop; a new read only fits below 2.
  assign occ        = 3'(cnt_q) + 3'(infl_q) - 3'(pop);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    cnt_d       = cnt_q;
    buf_dat_d   = buf_dat_q;
    buf_last_d  = buf_last_q;
    done_d      = 1'b0;

    if (pop) begin
      buf_dat_d[0]  = buf_dat_q[1];
      buf_last_d[0] = buf_last_q[1];
      cnt_d         = cnt_q - 2'd1;
    end
    if (infl_q) begin
      if (cnt_d == 2'd0) begin
        buf_dat_d[0]  = rom_data_i;
        buf_last_d[0] = infl_last_q;
      end else begin
        buf_dat_d[1]  = rom_data_i;
        buf_last_d[1] = infl_last_q;
      end
      cnt_d = cnt_d + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          last_d  = last_addr_i;
          state_d = RUN;
        end
      end
      RUN: begin
        // The ROM samples addr_q on this edge; the word lands in the buffer one edge later.
        if (occ < 3'd2) begin
          infl_d      = 1'b1;
          infl_last_d = (addr_q == last_q);
          if (addr_q == last_q) state_d = DRAIN;
          else                  addr_d  = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_d == 2'd0 && !infl_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_w && state_q != IDLE) begin
      state_d     = IDLE;
      cnt_d       = 2'd0;
      infl_d      = 1'b0;
      infl_last_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      buf_dat_q   <= '{default: '0};
      buf_last_q  <= '{default: 1'b0};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      buf_dat_q   <= buf_dat_d;
      buf_last_q  <= buf_last_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_rom_streamer.sv
// Scoreboard bench for rom_streamer against a ROM holding addr ^ 8'hA5.
module tb_rom_streamer;

  logic       clk = 1'b0;
  logic       rst_n, start, ready;
  logic [7:0] base, last_a, rom_addr, rom_data, m_data;
  logic       m_valid, m_last, busy, done;
`ifdef ROM_STREAMER_ABORT_EN
  logic       abort;
`endif

  always #5 clk = ~clk;

  rom_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .base_addr_i (base),
    .last_addr_i (last_a),
`ifdef ROM_STREAMER_ABORT_EN
    .abort_i     (abort),
`endif
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (ready),
    .m_last_o    (m_last),
    .busy_o      (busy),
    .done_o      (done)
  );

  always @(posedge clk) rom_data <= rom_addr ^ 8'hA5;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         xfers    = 0;
  int         done_cnt = 0;
  int         first_cyc, last_cyc, done_cyc;
  logic [8:0] exp_q [$];
  logic [8:0] e;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pop, stall stability, done tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(m_valid), 32'd1);
        check_eq("hold_data", 32'(m_data), 32'(prev_data));
        check_eq("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (!m_valid) check_eq("last_without_valid", 32'(m_last), 32'd0);
      if (m_valid && ready) begin
        check_eq("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("word_data", 32'(m_data), 32'(e[7:0]));
          check_eq("word_last", 32'(m_last), 32'(e[8]));
        end
        if (xfers == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfers++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic push_run(input logic [7:0] b, input logic [7:0] l, output int n);
    logic [7:0] span, a;
    span = l - b;
    n    = int'(span) + 1;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      exp_q.push_back({(i == n - 1), a ^ 8'hA5});
    end
  endtask

  task automatic run(input logic [7:0] b, input logic [7:0] l, input bit toggle, input bit chk_lat);
    int n, done0;
    bit got_done;
    push_run(b, l, n);
    xfers  = 0;
    done0  = done_cnt;
    ready  = 1'b1;
    base   = b;
    last_a = l;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (chk_lat) begin
      check_eq("lat_addr_e0", 32'(rom_addr), 32'(b));
      check_eq("lat_busy_e0", 32'(busy), 32'd1);
      check_eq("lat_valid_e0", 32'(m_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("lat_valid_e1", 32'(m_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("lat_valid_e2", 32'(m_valid), 32'd1);
    end
    got_done = 1'b0;
    for (int k = 0; k < 400 && !got_done; k++) begin
      if (done_cnt != done0) got_done = 1'b1;
      else begin
        @(posedge clk); #1;
        if (toggle) ready = ~ready;
      end
    end
    check_eq("run_done_seen", 32'(got_done), 32'd1);
    check_eq("run_words", 32'(xfers), 32'(n));
    check_eq("run_leftover", 32'(exp_q.size()), 32'd0);
    check_eq("run_done_once", 32'(done_cnt - done0), 32'd1);
    check_eq("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_valid", 32'(m_valid), 32'd0);
    check_eq("idle_addr_hold", 32'(rom_addr), 32'(l));
    if (!toggle) check_eq("back_to_back", 32'(last_cyc - first_cyc), 32'(n - 1));
    exp_q.delete();
    ready = 1'b1;
  endtask

  task automatic wait_xfers(input int target, input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); #1;
      if (xfers >= target) ok = 1'b1;
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic reset_mid_run();
    int n, done0;
    push_run(8'h20, 8'h2F, n);
    xfers  = 0;
    done0  = done_cnt;
    ready  = 1'b1;
    base   = 8'h20;
    last_a = 8'h2F;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_xfers(3, "rst_wait_3_words");
    rst_n = 1'b0;
    #1;
    check_eq("rst_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_data", 32'(m_data), 32'd0);
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_last", 32'(m_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    check_eq("rst_no_done", 32'(done_cnt - done0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef ROM_STREAMER_ABORT_EN
  task automatic abort_run();
    int n, done0;
    push_run(8'h80, 8'h8F, n);
    xfers  = 0;
    done0  = done_cnt;
    ready  = 1'b1;
    base   = 8'h80;
    last_a = 8'h8F;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_xfers(5, "abort_wait_5_words");
    abort  = 1'b1;
    start  = 1'b1;
    base   = 8'h00;
    last_a = 8'h03;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    exp_q.delete();
    check_eq("abort_valid", 32'(m_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check_eq("abort_start_ignored", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_no_done", 32'(done_cnt - done0), 32'd0);
    check_eq("abort_still_idle", 32'(m_valid), 32'd0);
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    ready  = 1'b1;
    base   = 8'h00;
    last_a = 8'h00;
`ifdef ROM_STREAMER_ABORT_EN
    abort  = 1'b0;
`endif
    #1;
    check_eq("reset_addr", 32'(rom_addr), 32'd0);
    check_eq("reset_data", 32'(m_data), 32'd0);
    check_eq("reset_valid", 32'(m_valid), 32'd0);
    check_eq("reset_last", 32'(m_last), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(8'h10, 8'h13, 1'b0, 1'b1);
    run(8'hFE, 8'h01, 1'b0, 1'b0);
    run(8'h40, 8'h40, 1'b0, 1'b0);
    run(8'h00, 8'h07, 1'b1, 1'b0);
    reset_mid_run();
    run(8'h30, 8'h35, 1'b0, 1'b1);
`ifdef ROM_STREAMER_ABORT_EN
    abort_run();
    run(8'hF0, 8'hF3, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_streamer.md
ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the ROM word width and stream data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the ROM address width; addressable depth is 2**ADDR_WIDTH.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port start_i  input  1  run request, sampled only in IDLE.
REQ-006 The block SHALL have port base_addr_i  input  ADDR_WIDTH  first ROM address of the run, captured with start_i.
REQ-007 The block SHALL have port last_addr_i  input  ADDR_WIDTH  final ROM address of the run (inclusive), captured with start_i.
REQ-008 The block SHALL have port rom_addr_o  output  ADDR_WIDTH  address to the synchronous ROM.
REQ-009 The block SHALL have port rom_data_i  input  DATA_WIDTH  ROM read data, valid exactly one clock after the address is presented; the ROM has no enable.
REQ-010 The block SHALL have port m_data_o  output  DATA_WIDTH  stream data.
REQ-011 The block SHALL have port m_valid_o  output  1  stream valid.
REQ-012 The block SHALL have port m_ready_i  input  1  stream ready from the sink.
REQ-013 The block SHALL have port m_last_o  output  1  marks the word read from last_addr.
REQ-014 The block SHALL have port busy_o  output  1  high while a run is in progress.
REQ-015 The block SHALL have port done_o  output  1  one-clock pulse when a run completes.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-017 IDLE with start_i=1 SHALL capture base/last, go to RUN, and set busy_o=1 on the next clock.
REQ-018 start_i SHALL be ignored outside IDLE.
REQ-019 RUN SHALL issue one address per clock, starting at base_addr, only when (buffer occupancy + in-flight reads - pops this cycle) < 2.
REQ-020 The output buffer SHALL be 2 words deep; each in-flight read SHALL be written to it on the clock after its address was issued.
REQ-021 The address SHALL increment modulo 2**ADDR_WIDTH; last_addr < base_addr SHALL wrap through the maximum address to 0; last_addr == base_addr SHALL yield exactly one word.
REQ-022 After issuing last_addr, the FSM SHALL go to DRAIN and issue no further addresses.
REQ-023 DRAIN SHALL wait until the buffer is empty with no read in flight, pulse done_o for one clock, and return to IDLE with busy_o=0 in that same clock.
REQ-024 A stream transfer SHALL occur when m_valid_o=1 and m_ready_i=1; while m_ready_i=0, m_data_o, m_valid_o and m_last_o SHALL hold stable.
REQ-025 m_last_o SHALL be asserted together with m_valid_o only for the word read from last_addr.
REQ-026 Latency: if start_i is sampled at edge E0, rom_addr_o SHALL equal base_addr after E0, and m_valid_o SHALL rise after E2.
REQ-027 With m_ready_i held high, the block SHALL sustain one word per clock.
REQ-028 In IDLE, rom_addr_o SHALL hold its last value and m_valid_o SHALL be 0.

Reset
REQ-029 rst_n_i low SHALL immediately force IDLE, empty the buffer and clear in-flight state, and drive rom_addr_o=0, m_data_o=0, m_valid_o=0, m_last_o=0, busy_o=0 and done_o=0.
REQ-030 Reset during RUN or DRAIN SHALL discard all pending words without producing a done_o pulse.
REQ-031 After rst_n_i releases, the first start_i SHALL be honoured on the first rising edge.

Configuration
REQ-032 With macro ROM_STREAMER_ABORT_EN defined, the block SHALL add input abort_i (1 bit).
REQ-033 With ROM_STREAMER_ABORT_EN, abort_i=1 in RUN or DRAIN SHALL flush the buffer and in-flight read and return to IDLE on the next clock, with m_valid_o=0, busy_o=0 and no done_o pulse.
REQ-034 With ROM_STREAMER_ABORT_EN, abort_i in IDLE SHALL be ignored, and abort_i takes priority over a simultaneous handshake.
REQ-035 Without ROM_STREAMER_ABORT_EN, port abort_i SHALL not exist and every run SHALL complete.

Verification
REQ-036 ROM holding data = addr XOR 8'hA5, base 8'h10, last 8'h13, ready high -> 4 words A5^10..A5^13 on consecutive clocks, m_last_o on the 4th, done_o one clock later.
REQ-037 base 8'hFE, last 8'h01 -> words for FE, FF, 00, 01 in that order, m_last_o only with 01.
REQ-038 base = last = 8'h40 -> single word 8'hE5 with m_last_o=1, then done_o.
REQ-039 base 0, last 7, m_ready_i toggled 1-0-1-0 -> all 8 words in order, none dropped or duplicated, data stable while ready=0, and occupancy never above 2.
REQ-040 rst_n_i pulsed low mid-run (after 3rd word) -> outputs reach reset values without waiting for a clock, no done_o, and a new start then runs cleanly.
REQ-041 With ROM_STREAMER_ABORT_EN, abort_i during a 16-word run after word 5 -> IDLE next clock, m_valid_o=0, no done_o, and start_i in that same cycle is ignored.
